// File: rtl/multiply_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the EX controller that drives it.
package multiply_unit_pkg;

    // Bit positions inside the 5-bit ctrl word {launch, divide, unsigned, move, target_LO}
    localparam int unsigned CtrlLaunch   = 4;
    localparam int unsigned CtrlDivide   = 3;
    localparam int unsigned CtrlUnsigned = 2;
    localparam int unsigned CtrlMove     = 1;
    localparam int unsigned CtrlTargetLo = 0;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

    localparam int unsigned CntWidth = 16;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/multiply_unit_divide_core.sv
// Combinational signed/unsigned divider producing quotient, remainder and a divide-by-zero flag.
module multiply_unit_divide_core (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        unsigned_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        div_by_zero_o
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide on magnitudes so truncation is toward zero; 0x80000000 negates to itself and
    // still reads correctly as an unsigned magnitude.
    always_comb begin
        neg_a         = ~unsigned_i & a_i[31];
        neg_b         = ~unsigned_i & b_i[31];
        a_mag         = neg_a ? -a_i : a_i;
        b_mag         = neg_b ? -b_i : b_i;
        div_by_zero_o = (b_i == 32'd0);
        b_safe        = div_by_zero_o ? 32'd1 : b_mag;
        q_mag         = a_mag / b_safe;
        r_mag         = a_mag % b_safe;
        quot_o        = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem_o         = neg_a ? -r_mag : r_mag;
    end

endmodule

// File: rtl/multiply_unit.sv
// Multi-cycle HI/LO multiply/divide unit: results are computed at launch, held in pending
// registers and committed to HI/LO after a fixed busy period.
module multiply_unit
    import multiply_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ctrl,
    input  logic        cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] result
);

    localparam logic [CntWidth-1:0] MultCnt = CntWidth'(MULT_CYCLES);
    localparam logic [CntWidth-1:0] DivCnt  = CntWidth'(DIV_CYCLES);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [31:0]         hi_q, hi_d, lo_q, lo_d;
    logic [31:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [63:0]         a_ext, b_ext, product;
    logic [31:0]         quot, rem;
    logic                div_by_zero;
    logic                idle, move;

    multiply_unit_divide_core u_divide_core (
        .a_i           (A),
        .b_i           (B),
        .unsigned_i    (ctrl[CtrlUnsigned]),
        .quot_o        (quot),
        .rem_o         (rem),
        .div_by_zero_o (div_by_zero)
    );

    assign a_ext   = ctrl[CtrlUnsigned] ? {32'd0, A} : {{32{A[31]}}, A};
    assign b_ext   = ctrl[CtrlUnsigned] ? {32'd0, B} : {{32{B[31]}}, B};
    assign product = a_ext * b_ext;

    assign idle   = (state_q == StIdle);
    assign start  = ctrl[CtrlLaunch] & ~cancel & idle;
    assign move   = ctrl[CtrlMove] & ~ctrl[CtrlLaunch] & ~cancel & idle;
    assign busy   = (state_q == StBusy);
    assign result = ctrl[CtrlTargetLo] ? lo_q : hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    if (ctrl[CtrlDivide]) begin
                        cnt_d = DivCnt;
                        // Divide by zero re-commits the current HI/LO, leaving them unchanged
                        pend_hi_d = div_by_zero ? hi_q : rem;
                        pend_lo_d = div_by_zero ? lo_q : quot;
                    end else begin
                        cnt_d     = MultCnt;
                        pend_hi_d = product[63:32];
                        pend_lo_d = product[31:0];
                    end
                end else if (move) begin
                    if (ctrl[CtrlTargetLo]) begin
                        lo_d = A;
                    end else begin
                        hi_d = A;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q <= CntWidth'(1)) begin
                    state_d = StIdle;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule

// File: tb/tb_multiply_unit.sv
// Directed, table-driven bench for multiply_unit with hand-computed HI/LO results.
module tb_multiply_unit;

    localparam logic [4:0] OpMult  = 5'b10000;
    localparam logic [4:0] OpMultu = 5'b10100;
    localparam logic [4:0] OpDiv   = 5'b11000;
    localparam logic [4:0] OpDivu  = 5'b11100;
    localparam logic [4:0] OpMthi  = 5'b00010;
    localparam logic [4:0] OpMtlo  = 5'b00011;
    localparam logic [4:0] OpMfhi  = 5'b00000;
    localparam logic [4:0] OpMflo  = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [4:0]  ctrl;
    logic        cancel;
    logic        start, busy;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    multiply_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .ctrl   (ctrl),
        .cancel (cancel),
        .start  (start),
        .busy   (busy),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          poke;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        ctrl = OpMfhi;
        #1;
        check({name, " HI"}, result, eh);
        ctrl = OpMflo;
        #1;
        check({name, " LO"}, result, el);
        ctrl = OpMfhi;
    endtask

    // Called mid launch cycle; returns mid-cycle in the first idle cycle after the op.
    task automatic wait_busy(input string name, input logic [4:0] c, input int n, input bit poke);
        int cnt = 0;
        bit bad_start = 0;
        bit done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (poke) begin
                ctrl   = (i % 2 == 0) ? c : OpMtlo;
                A      = 32'hBAD0BAD0;
                cancel = (i % 3 == 0);
            end else begin
                ctrl   = OpMfhi;
                cancel = 1'b0;
            end
            #1;
            if (!busy) done = 1;
            else begin
                cnt++;
                if (start) bad_start = 1;
            end
        end
        ctrl   = OpMfhi;
        cancel = 1'b0;
        check({name, " busy_len"}, cnt, n);
        check({name, " done"}, {31'd0, done}, 32'd1);
        if (poke) check({name, " start_in_busy"}, {31'd0, bad_start}, 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        ctrl   = v.c;
        A      = v.a;
        B      = v.b;
        cancel = 1'b0;
        #1;
        check({v.name, " start"}, {31'd0, start}, 32'd1);
        check({v.name, " busy_at_launch"}, {31'd0, busy}, 32'd0);
        wait_busy(v.name, v.c, v.n, v.poke);
        read_hilo(v.name, v.hi, v.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;

        vecs[0] = '{"mult_neg2x3",   OpMult,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 0};
        vecs[1] = '{"multu_max_x2",  OpMultu, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, 0};
        vecs[2] = '{"div_m7_2",      OpDiv,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1};
        vecs[3] = '{"mult_min_sq",   OpMult,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000, 0};
        vecs[4] = '{"multu_x16",     OpMultu, 32'h12345678, 32'h10,       5,  32'h00000001, 32'h23456780, 0};
        vecs[5] = '{"div_min_m1",    OpDiv,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0};
        vecs[6] = '{"divu_100_7",    OpDivu,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E, 0};
        vecs[7] = '{"div_7_m2",      OpDiv,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 0};
        vecs[8] = '{"divu_max_16",   OpDivu,  32'hFFFFFFFF, 32'h10,       10, 32'h0000000F, 32'h0FFFFFFF, 0};
        vecs[9] = '{"mult_7_m3",     OpMult,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB, 1};

        // Reset state
        reset  = 1'b1;
        ctrl   = OpMfhi;
        cancel = 1'b0;
        A      = 32'h0;
        B      = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        read_hilo("reset", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ctrl  = OpMult;
        #1;
        check("post_reset start", {31'd0, start}, 32'd1);
        cancel = 1'b1;
        #1;
        check("post_reset start_cancel", {31'd0, start}, 32'd0);
        ctrl   = OpMfhi;
        cancel = 1'b0;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Cancelled launch and cancelled move leave HI/LO alone
        @(negedge clk);
        ctrl   = OpMult;
        A      = 32'd9;
        B      = 32'd9;
        cancel = 1'b1;
        #1;
        check("cancel start", {31'd0, start}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ctrl   = (i == 0) ? OpMtlo : OpMfhi;
            A      = 32'hDEAD0000;
            cancel = (i == 0);
            #1;
            if (busy) seen++;
        end
        cancel = 1'b0;
        check("cancel busy_seen", seen, 0);
        read_hilo("cancel", 32'hFFFFFFFF, 32'hFFFFFFEB);

        // mtlo then mflo next cycle; mthi then divu by zero keeps HI/LO
        @(negedge clk);
        ctrl = OpMtlo;
        A    = 32'hDEADBEEF;
        @(negedge clk);
        ctrl = OpMflo;
        #1;
        check("mtlo readback", result, 32'hDEADBEEF);
        ctrl = OpMthi;
        A    = 32'h00001234;
        @(negedge clk);
        read_hilo("mthi", 32'h00001234, 32'hDEADBEEF);
        run_op('{"divu_by0", OpDivu, 32'd77, 32'd0, 10, 32'h00001234, 32'hDEADBEEF, 0});

        // Back-to-back launch in the first idle cycle
        run_op(vecs[0]);
        ctrl = OpMult;
        A    = 32'd5;
        B    = 32'd6;
        #1;
        check("b2b start", {31'd0, start}, 32'd1);
        wait_busy("b2b", OpMult, 5, 0);
        read_hilo("b2b", 32'h0, 32'h0000001E);

        // Reset in cycle T+3 of a divide
        @(negedge clk);
        ctrl = OpDiv;
        A    = 32'd100;
        B    = 32'd7;
        #1;
        check("rst_mid start", {31'd0, start}, 32'd1);
        @(negedge clk);
        ctrl = OpMfhi;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid busy_after", {31'd0, busy}, 32'd0);
        read_hilo("rst_mid", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (busy) seen++;
        end
        check("rst_mid busy_seen", seen, 0);
        read_hilo("rst_mid_late", 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
